// File: rtl/control_interrupciones.sv
// ---------------------------------------------------------------------------
// control_interrupciones
//
// Interrupt controller between the system peripherals (RTC, keyboard, VGA,
// sound) and the KCPSM6 core. It edge-detects four request lines, holds them
// as pending bits, raises the core's single `interrupt` input, arbitrates
// among enabled pending sources and tracks one in-service source until the
// firmware writes end-of-interrupt.
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> rotating priority (source after the last
//                                acknowledged one is highest, 3 wraps to 0;
//                                the pointer resets to 3 so source 0 is first)
//                   undefined -> fixed priority 0 (RTC) > 1 > 2 > 3 (sonido)
//
// Ports:
//   clk           in   1  system clock
//   reset_n       in   1  asynchronous active-low reset
//   irq_src       in   4  request lines [0]=RTC [1]=teclado [2]=VGA [3]=sonido
//   port_id       in   8  KCPSM6 port address
//   out_port      in   8  KCPSM6 write data
//   write_strobe  in   1  KCPSM6 write strobe
//   read_strobe   in   1  KCPSM6 read strobe (no side effects)
//   in_port       out  8  registered read data to KCPSM6
//   interrupt     out  1  interrupt request to KCPSM6
//   interrupt_ack in   1  single-cycle acknowledge from KCPSM6
//
// Port map (parameters):
//   PORT_STATUS  read-only  {pending[3:0], in_service, requesting, active_id}
//   PORT_MASK    read/write {4'b0, mask[3:0]}
//   PORT_EOI     write-only end of interrupt, data ignored
//
// Handshake: `interrupt` stays high while the controller is requesting; the
// core answers with a one-cycle `interrupt_ack`. The winner is chosen from the
// enabled pending sources in that ack cycle, so a higher-priority edge that
// arrives while the request is outstanding still wins. The controller then
// holds that source in service until a write to PORT_EOI.
// ---------------------------------------------------------------------------
module control_interrupciones #(
    parameter logic [7:0] PORT_STATUS = 8'h20,
    parameter logic [7:0] PORT_MASK   = 8'h21,
    parameter logic [7:0] PORT_EOI    = 8'h22
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] irq_src,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] irq_prev;
    logic [3:0] rise;
    logic [3:0] pending;
    logic [3:0] mask;
    logic [3:0] candidates;
    logic [3:0] clear_bits;
    logic [1:0] active_id;
    logic [1:0] winner;
    logic       take_ack;
    logic       mask_wr;
    logic       eoi_wr;
    logic [7:0] status;

    // Reads are side-effect free and the upper write-data bits carry nothing.
    logic       unused_inputs;
    assign unused_inputs = &{1'b0, read_strobe, out_port[7:4]};

    // -----------------------------------------------------------------------
    // Request edge detection and port decode
    // -----------------------------------------------------------------------
    assign rise       = irq_src & ~irq_prev;
    assign candidates = pending & mask;
    assign mask_wr    = write_strobe && (port_id == PORT_MASK);
    assign eoi_wr     = write_strobe && (port_id == PORT_EOI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev <= 4'h0;
        end else begin
            irq_prev <= irq_src;
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration among candidates
    // -----------------------------------------------------------------------
`ifdef ROUND_ROBIN_EN
    logic [1:0] last_ack;
    logic       found;

    // Search starts one past the last acknowledged source and wraps; k=4
    // lands back on last_ack itself, so it is considered last.
    always_comb begin
        winner = last_ack + 2'd1;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && candidates[last_ack + 2'(k)]) begin
                winner = last_ack + 2'(k);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ack <= 2'd3;
        end else if (take_ack) begin
            last_ack <= winner;
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        if (candidates[0]) begin
            winner = 2'd0;
        end else if (candidates[1]) begin
            winner = 2'd1;
        end else if (candidates[2]) begin
            winner = 2'd2;
        end else if (candidates[3]) begin
            winner = 2'd3;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (candidates != 4'h0) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                // Firmware masking everything withdraws the request, even if
                // an ack arrives in the same cycle: there is nothing to serve.
                if (candidates == 4'h0) begin
                    next_state = ST_IDLE;
                end else if (interrupt_ack) begin
                    next_state = ST_SERV;
                    take_ack   = 1'b1;
                end
            end
            ST_SERV: begin
                if (eoi_wr) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register so that reset removes the
    // request immediately, without waiting for a clock edge.
    assign interrupt = (state == ST_REQ);

    // -----------------------------------------------------------------------
    // Pending bits, mask and in-service id
    // -----------------------------------------------------------------------
    assign clear_bits = take_ack ? (4'b0001 << winner) : 4'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 4'h0;
        end else begin
            // A new edge in the same cycle as its own acknowledge must not
            // be lost, so the set term is applied after the clear.
            pending <= (pending & ~clear_bits) | rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= 4'h0;
        end else if (mask_wr) begin
            mask <= out_port[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_id <= 2'd0;
        end else if (take_ack) begin
            active_id <= winner;
        end
    end

    // -----------------------------------------------------------------------
    // Read data: registered one cycle after port_id, which KCPSM6 holds for
    // two cycles, so the value is valid while read_strobe is high.
    // -----------------------------------------------------------------------
    assign status = {pending, (state == ST_SERV), (state == ST_REQ), active_id};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_port <= 8'h00;
        end else if (port_id == PORT_STATUS) begin
            in_port <= status;
        end else if (port_id == PORT_MASK) begin
            in_port <= {4'h0, mask};
        end else begin
            in_port <= 8'h00;
        end
    end

endmodule
